decode_ctrl: RTL and testbench
==============================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: instrD  input  32  instruction in decode (D) stage.
REQ-004 SHALL have ports: validD  input  1  instrD holds a real instruction.
REQ-005 SHALL have ports: pcSrcE  input  1  branch/jump taken, resolved in execute (E) stage.
REQ-006 SHALL have ports: immSrcD  output  2  immediate-format select to the D-stage sign extender: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have ports: regWriteE, memWriteE, aluSrcE, branchE, jumpE  output  1 each  registered E-stage controls.
REQ-008 SHALL have ports: resultSrcE  output  2  00 ALU, 01 memory, 10 PC+4; aluOpE  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-009 SHALL have ports: rs1E, rs2E, rdE  output  5 each  registered register indices.
REQ-010 SHALL have ports: validE, illegalE  output  1 each; stallF, stallD, flushD  output  1 each  combinational hazard controls.

Function
REQ-011 SHALL decode instrD[6:0] combinationally: 0000011 lw (I, regWrite, aluSrc, resultSrc 01); 0100011 sw (S, memWrite, aluSrc); 0110011 R-type (regWrite, aluOp 10); 0010011 I-ALU (I, regWrite, aluSrc, aluOp 10); 1100011 beq (B, branch, aluOp 01).
REQ-012 SHALL treat any other opcode as illegal: all write/branch/jump controls 0, immSrcD 00, illegal flag 1.
REQ-013 SHALL treat rs1 as used for all legal opcodes except jal, and rs2 as used only for sw, R-type and beq.
REQ-014 SHALL assert load-use hazard when validE=1, resultSrcE=01, rdE!=0, and rdE equals a used rs1D or rs2D.
REQ-015 SHALL implement FSM RUN/STALL: RUN->STALL on load-use hazard with pcSrcE=0; STALL->RUN unconditionally next cycle.
REQ-016 SHALL hold stallF=stallD=1 exactly in the hazard cycle (one-cycle stall per load-use event), else 0.
REQ-017 SHALL load a bubble into E (validE=0, all controls 0, indices 0) on the clock edge when a hazard or pcSrcE=1 is present.
REQ-018 SHALL assert flushD=pcSrcE combinationally; flush SHALL take priority over stall (stallF=stallD=0 and FSM stays RUN when both occur).
REQ-019 SHALL otherwise register decoded controls, instrD[19:15], [24:20], [11:7] and validD into E each cycle, with illegalE=illegal&validD.
REQ-020 SHALL force all E controls to 0 when validD=0, regardless of instrD.
REQ-021 SHALL give the E-stage latency of exactly one cycle from D to E when no stall/flush.

Reset
REQ-022 SHALL, while rst=1, asynchronously clear all E-stage outputs to 0 and force the FSM to RUN.
REQ-023 SHALL, on rst mid-stall, abandon the stall: stallF/stallD 0 the cycle after rst falls unless a new hazard exists.
REQ-024 SHALL produce no hazard from E-stage state while in reset (validE=0).

Configuration
REQ-025 SHALL support macro DECODE_JAL_EN: defined -> opcode 1101111 decodes as jal (immSrcD 11, regWrite, jump, resultSrc 10, no rs used).
REQ-026 SHALL, without DECODE_JAL_EN, decode 1101111 as illegal per REQ-012, with immSrcD never 11.

Verification
REQ-027 SHALL cover: instrD=0x00402083 (lw x1,4(x0)) valid -> immSrcD=00; next cycle regWriteE=1, resultSrcE=01, rdE=1, validE=1.
REQ-028 SHALL cover: lw x1 in E, instrD=0x001101B3 (add x3,x2,x1) -> stallF=stallD=1 for one cycle, bubble in E, then add enters E with rs2E=1.
REQ-029 SHALL cover: lw x0 in E followed by add using x0 -> no stall.
REQ-030 SHALL cover: pcSrcE=1 together with a load-use hazard -> flushD=1, stallF=0, validE=0 next cycle, FSM RUN.
REQ-031 SHALL cover: instrD=0x0000006F valid -> with DECODE_JAL_EN, immSrcD=11, jumpE=1; without it, illegalE=1, all controls 0.
REQ-032 SHALL cover: rst pulsed during STALL -> all E outputs 0 immediately, stallF=0 after release.

Source files
------------

// File: rtl/decode_ctrl.sv
// decode_ctrl: D-stage instruction decode, one-cycle load-use stall control
// and D->E pipeline register for a small RISC-V style pipeline.
// Optional feature macro: DECODE_JAL_EN (when defined, opcode 1101111 decodes
// as jal; otherwise it is illegal and immSrcD never reaches 11).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | normal issue; a load-use hazard without redirect stalls once
// S_STALL | bubble just entered E; always returns to S_RUN next cycle

module decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic        validD,
    input  logic        pcSrcE,
    output logic [1:0]  immSrcD,
    output logic        regWriteE,
    output logic        memWriteE,
    output logic        aluSrcE,
    output logic        branchE,
    output logic        jumpE,
    output logic [1:0]  resultSrcE,
    output logic [1:0]  aluOpE,
    output logic [4:0]  rs1E,
    output logic [4:0]  rs2E,
    output logic [4:0]  rdE,
    output logic        validE,
    output logic        illegalE,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD
);

    typedef enum logic {S_RUN, S_STALL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_regWrite;
    logic        w_memWrite;
    logic        w_aluSrc;
    logic        w_branch;
    logic        w_jump;
    logic [1:0]  w_resultSrc;
    logic [1:0]  w_aluOp;
    logic [1:0]  w_immSrc;
    logic        w_illegal;
    logic        w_useRs1;
    logic        w_useRs2;
    logic        w_hazard;
    logic        w_stall;
    logic        w_bubble;
    logic [4:0]  w_rs1D;
    logic [4:0]  w_rs2D;
    logic [4:0]  w_rdD;
    logic        w_unused_bits;

    assign w_rs1D        = instrD[19:15];
    assign w_rs2D        = instrD[24:20];
    assign w_rdD         = instrD[11:7];
    assign w_unused_bits = ^{instrD[31:25], instrD[14:12]};

    // Opcode decode into control signals and register-use flags.
    always_comb begin
        w_regWrite  = 1'b0;
        w_memWrite  = 1'b0;
        w_aluSrc    = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_resultSrc = 2'b00;
        w_aluOp     = 2'b00;
        w_immSrc    = 2'b00;
        w_illegal   = 1'b0;
        w_useRs1    = 1'b0;
        w_useRs2    = 1'b0;
        case (instrD[6:0])
            7'b0000011: begin
                w_regWrite  = 1'b1;
                w_aluSrc    = 1'b1;
                w_resultSrc = 2'b01;
                w_useRs1    = 1'b1;
            end
            7'b0100011: begin
                w_immSrc    = 2'b01;
                w_memWrite  = 1'b1;
                w_aluSrc    = 1'b1;
                w_useRs1    = 1'b1;
                w_useRs2    = 1'b1;
            end
            7'b0110011: begin
                w_regWrite  = 1'b1;
                w_aluOp     = 2'b10;
                w_useRs1    = 1'b1;
                w_useRs2    = 1'b1;
            end
            7'b0010011: begin
                w_regWrite  = 1'b1;
                w_aluSrc    = 1'b1;
                w_aluOp     = 2'b10;
                w_useRs1    = 1'b1;
            end
            7'b1100011: begin
                w_immSrc    = 2'b10;
                w_branch    = 1'b1;
                w_aluOp     = 2'b01;
                w_useRs1    = 1'b1;
                w_useRs2    = 1'b1;
            end
`ifdef DECODE_JAL_EN
            7'b1101111: begin
                w_immSrc    = 2'b11;
                w_regWrite  = 1'b1;
                w_jump      = 1'b1;
                w_resultSrc = 2'b10;
            end
`endif
            default: begin
                w_illegal   = 1'b1;
            end
        endcase
    end

    // Load in E whose destination feeds a source the D instruction reads.
    // Reset clears validE, so no hazard can originate from E while in reset.
    assign w_hazard = validE && (resultSrcE == 2'b01) && (rdE != 5'd0) &&
                      ((w_useRs1 && (w_rs1D == rdE)) ||
                       (w_useRs2 && (w_rs2D == rdE)));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and stall output; a redirect overrides the stall.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_hazard && !pcSrcE) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign stallF   = w_stall;
    assign stallD   = w_stall;
    assign flushD   = pcSrcE;
    assign immSrcD  = w_immSrc;
    assign w_bubble = w_stall || pcSrcE;

    // D->E pipeline register; bubble on stall or redirect, controls gated by validD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            regWriteE  <= 1'b0;
            memWriteE  <= 1'b0;
            aluSrcE    <= 1'b0;
            branchE    <= 1'b0;
            jumpE      <= 1'b0;
            resultSrcE <= 2'b00;
            aluOpE     <= 2'b00;
            rs1E       <= 5'd0;
            rs2E       <= 5'd0;
            rdE        <= 5'd0;
            validE     <= 1'b0;
            illegalE   <= 1'b0;
        end else begin
            regWriteE  <= w_regWrite && validD;
            memWriteE  <= w_memWrite && validD;
            aluSrcE    <= w_aluSrc && validD;
            branchE    <= w_branch && validD;
            jumpE      <= w_jump && validD;
            resultSrcE <= validD ? w_resultSrc : 2'b00;
            aluOpE     <= validD ? w_aluOp : 2'b00;
            rs1E       <= w_rs1D;
            rs2E       <= w_rs2D;
            rdE        <= w_rdD;
            validE     <= validD;
            illegalE   <= w_illegal && validD;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Testbench for decode_ctrl: directed scenarios then randomized traffic,
// checked against a pipeline reference model built from the opcode table.
module tb_decode_ctrl;

    typedef struct packed {
        logic       regw;
        logic       memw;
        logic       alusrc;
        logic       br;
        logic       jmp;
        logic [1:0] res;
        logic [1:0] aluop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       v;
        logic       ill;
    } e_t;

    logic        clk;
    logic        rst;
    logic [31:0] instrD;
    logic        validD;
    logic        pcSrcE;
    logic [1:0]  immSrcD;
    logic        regWriteE, memWriteE, aluSrcE, branchE, jumpE;
    logic [1:0]  resultSrcE, aluOpE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic        validE, illegalE, stallF, stallD, flushD;

    int checks = 0;
    int errors = 0;
    e_t exp_e;
    logic last_stall;

    decode_ctrl dut (
        .clk(clk), .rst(rst), .instrD(instrD), .validD(validD), .pcSrcE(pcSrcE),
        .immSrcD(immSrcD), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .aluSrcE(aluSrcE), .branchE(branchE), .jumpE(jumpE),
        .resultSrcE(resultSrcE), .aluOpE(aluOpE), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .validE(validE), .illegalE(illegalE), .stallF(stallF),
        .stallD(stallD), .flushD(flushD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic e_t dut_e();
        return {regWriteE, memWriteE, aluSrcE, branchE, jumpE, resultSrcE,
                aluOpE, rs1E, rs2E, rdE, validE, illegalE};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Opcode table: immediate format, E-stage contents for a valid instruction, sources read.
    function automatic void ref_decode(input logic [31:0] ins, output logic [1:0] imm,
                                       output e_t c, output logic u1, output logic u2);
        c     = '0;
        imm   = 2'b00;
        u1    = 1'b0;
        u2    = 1'b0;
        c.rs1 = ins[19:15];
        c.rs2 = ins[24:20];
        c.rd  = ins[11:7];
        c.v   = 1'b1;
        case (ins[6:0])
            7'h03: begin c.regw = 1; c.alusrc = 1; c.res = 2'b01; u1 = 1; end
            7'h23: begin imm = 2'b01; c.memw = 1; c.alusrc = 1; u1 = 1; u2 = 1; end
            7'h33: begin c.regw = 1; c.aluop = 2'b10; u1 = 1; u2 = 1; end
            7'h13: begin c.regw = 1; c.alusrc = 1; c.aluop = 2'b10; u1 = 1; end
            7'h63: begin imm = 2'b10; c.br = 1; c.aluop = 2'b01; u1 = 1; u2 = 1; end
`ifdef DECODE_JAL_EN
            7'h6F: begin imm = 2'b11; c.regw = 1; c.jmp = 1; c.res = 2'b10; end
`endif
            default: c.ill = 1'b1;
        endcase
    endfunction

    // One cycle: drive at negedge, check combinational outputs, clock, check E.
    task automatic step(input string tag, input logic [31:0] ins, input logic vd, input logic pc);
        logic [1:0] imm;
        e_t c;
        logic u1, u2, haz, stl;
        instrD = ins;
        validD = vd;
        pcSrcE = pc;
        ref_decode(ins, imm, c, u1, u2);
        if (!vd) begin
            c.regw = 0; c.memw = 0; c.alusrc = 0; c.br = 0; c.jmp = 0;
            c.res = 0; c.aluop = 0; c.v = 0; c.ill = 0;
        end
        haz = exp_e.v && (exp_e.res == 2'b01) && (exp_e.rd != 0) &&
              ((u1 && ins[19:15] == exp_e.rd) || (u2 && ins[24:20] == exp_e.rd));
        stl = haz && !pc;
        #1;
        chk({tag, ".imm"},   32'(immSrcD), 32'(imm));
        chk({tag, ".stallF"}, 32'(stallF), 32'(stl));
        chk({tag, ".stallD"}, 32'(stallD), 32'(stl));
        chk({tag, ".flushD"}, 32'(flushD), 32'(pc));
        exp_e = (haz || pc) ? e_t'(0) : c;
        last_stall = stl;
        @(posedge clk);
        #1;
        chk({tag, ".E"}, 32'(dut_e()), 32'(exp_e));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        logic [6:0]  ops [7];
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
        ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h7F;

        rst = 1'b1; instrD = '0; validD = 1'b0; pcSrcE = 1'b0;
        exp_e = '0; last_stall = 1'b0;
        #2;
        chk("reset.E", 32'(dut_e()), 32'(exp_e));
        chk("reset.stallF", 32'(stallF), 32'(0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // lw x1,4(x0): one-cycle latency into E
        step("lw", 32'h00402083, 1, 0);
        chk("lw.regWriteE", 32'(regWriteE), 32'(1));
        chk("lw.rdE", 32'(rdE), 32'(1));
        // add x3,x2,x1 dependent on lw: stall, bubble, then add enters E
        step("lu.stall", 32'h001101B3, 1, 0);
        chk("lu.bubble", 32'(validE), 32'(0));
        step("lu.replay", 32'h001101B3, 1, 0);
        chk("lu.rs2E", 32'(rs2E), 32'(1));

        // lw x0 then add using x0: no stall
        step("lwx0", 32'h00402003, 1, 0);
        step("x0.add", 32'h000001B3, 1, 0);
        chk("x0.nostall", 32'(stallF), 32'(0));

        // redirect together with load-use hazard: flush wins
        step("pc.lw", 32'h00402083, 1, 0);
        step("pc.haz", 32'h001101B3, 1, 1);
        chk("pc.validE", 32'(validE), 32'(0));
        step("pc.after", 32'h001101B3, 1, 0);

        // jal encoding
        step("jal", 32'h0000006F, 1, 0);
`ifdef DECODE_JAL_EN
        chk("jal.jumpE", 32'(jumpE), 32'(1));
`else
        chk("jal.illegalE", 32'(illegalE), 32'(1));
`endif

        // invalid slot: controls forced off
        step("inv", 32'h00402083, 0, 0);

        // reset pulsed during a stall cycle
        step("rs.lw", 32'h00402083, 1, 0);
        instrD = 32'h001101B3; validD = 1'b1; pcSrcE = 1'b0;
        #1;
        chk("rs.stall", 32'(stallF), 32'(1));
        rst = 1'b1;
        #1;
        exp_e = '0;
        chk("rs.E", 32'(dut_e()), 32'(exp_e));
        chk("rs.stallF", 32'(stallF), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("rs.after", 32'h001101B3, 1, 0);

        // randomized traffic; D instruction held while stalled
        held = 32'h0;
        last_stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                r = $urandom;
                r[6:0]   = ops[$urandom_range(0, 6)];
                r[11:7]  = 5'($urandom_range(0, 3));
                r[19:15] = 5'($urandom_range(0, 3));
                r[24:20] = 5'($urandom_range(0, 3));
                held = r;
            end
            step("rand", held, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
